riscv_instr_req_slice: RTL and testbench

Register slice on the instruction-fetch bus, between the prefetch buffer's memory-side port and the instruction memory or cache.
- Request path: accepts prefetch requests (req/gnt/addr), holds them in one registered slot and re-issues them downstream. This cuts the combinational gnt/addr path between memory and the fetch FSM.
- Response path: returns rdata/rvalid/err in order, either passed through or registered (selected by parameter).
- Tracks outstanding transactions so the core never has more in flight than the memory contract allows.

---
 rtl/riscv_instr_req_slice_pkg.sv | 17 +
 rtl/riscv_instr_resp_reg.sv | 37 +++
 rtl/riscv_instr_req_slice.sv | 103 ++++++++++
 tb/tb_riscv_instr_req_slice.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_instr_req_slice_pkg.sv
// Shared constants and helpers for the instruction-fetch request slice.
package riscv_instr_req_slice_pkg;

  localparam int unsigned ADDR_W = 32;

  // Outstanding-counter update: +1 on grant, -1 on response, both cancel.
  // A decrement at zero saturates rather than wrapping (stray response).
  function automatic logic [2:0] cnt_next(input logic [2:0] c, input logic inc,
                                          input logic dec);
    logic [2:0] n;
    n = c;
    if (inc && !dec)                n = c + 3'd1;
    else if (!inc && dec && c != 0) n = c - 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/riscv_instr_resp_reg.sv
// Optional response register stage: adds one cycle of latency on rvalid/rdata/err.
module riscv_instr_resp_reg #(
  parameter int unsigned RDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rvalid_i,
  input  logic [RDATA_WIDTH-1:0] rdata_i,
  input  logic                   err_i,
  output logic                   rvalid_o,
  output logic [RDATA_WIDTH-1:0] rdata_o,
  output logic                   err_o
);

  logic                   rvalid_q;
  logic                   err_q;
  logic [RDATA_WIDTH-1:0] rdata_q;

  // Valid and error follow the input every cycle; data only loads on a
  // valid response so it holds the last returned word otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_i;
      err_q    <= err_i & rvalid_i;
      if (rvalid_i) rdata_q <= rdata_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q & rvalid_q;

endmodule

// File: rtl/riscv_instr_req_slice.sv
// Register slice between the prefetch buffer and instruction memory.
// One registered request slot breaks the gnt/addr combinational path;
// an outstanding counter bounds in-flight fetches at the core side.
module riscv_instr_req_slice
  import riscv_instr_req_slice_pkg::*;
#(
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          RESP_REG        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_req_i,
  output logic                   core_gnt_o,
  input  logic [ADDR_W-1:0]      core_addr_i,
  output logic [RDATA_WIDTH-1:0] core_rdata_o,
  output logic                   core_rvalid_o,
  output logic                   core_err_o,
  output logic                   instr_req_o,
  input  logic                   instr_gnt_i,
  output logic [ADDR_W-1:0]      instr_addr_o,
  input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
  input  logic                   instr_rvalid_i,
  input  logic                   instr_err_i,
  output logic                   busy_o
);

  localparam int unsigned      CNT_W   = 3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic              slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_gnt;
  logic              core_rvalid;

  // Grant depends only on the request and local state, never on instr_gnt_i,
  // so the slot cannot refill in the cycle it drains.
  assign core_gnt = core_req_i & ~slot_valid_q & (cnt_q < MAX_CNT);

  // Slot and counter next state: fill on core grant, drain on memory grant.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    if (core_gnt) begin
      slot_valid_d = 1'b1;
      slot_addr_d  = core_addr_i;
    end else if (slot_valid_q && instr_gnt_i) begin
      slot_valid_d = 1'b0;
    end
    cnt_d = cnt_next(cnt_q, core_gnt, core_rvalid);
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      cnt_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign core_gnt_o   = core_gnt;
  assign instr_req_o  = slot_valid_q;
  assign instr_addr_o = slot_addr_q;
  assign busy_o       = slot_valid_q | (cnt_q != '0) | core_req_i;

  generate
    if (RESP_REG) begin : g_resp_reg
      riscv_instr_resp_reg #(
        .RDATA_WIDTH(RDATA_WIDTH)
      ) u_resp_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .rvalid_i(instr_rvalid_i),
        .rdata_i (instr_rdata_i),
        .err_i   (instr_err_i),
        .rvalid_o(core_rvalid),
        .rdata_o (core_rdata_o),
        .err_o   (core_err_o)
      );
    end else begin : g_resp_comb
      assign core_rvalid  = instr_rvalid_i;
      assign core_rdata_o = instr_rdata_i;
      assign core_err_o   = instr_err_i & instr_rvalid_i;
    end
  endgenerate

  assign core_rvalid_o = core_rvalid;

  // A memory response with nothing outstanding is a protocol violation.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_i |-> (cnt_q != '0));

  // The grant condition keeps the counter within the configured limit.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= MAX_CNT);

endmodule

// File: tb/tb_riscv_instr_req_slice.sv
// Bench for riscv_instr_req_slice: one instance per response mode, directed
// scenarios then random traffic, all checked against a transaction-level model.
module tb_riscv_instr_req_slice;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2];
  logic [31:0] addr[2];
  logic        ign[2];
  logic        irv[2];
  logic [31:0] ird[2];
  logic        ier[2];
  logic        gnt[2];
  logic        irq[2];
  logic [31:0] iad[2];
  logic        crv[2];
  logic [31:0] crd[2];
  logic        cer[2];
  logic        busy[2];

  int ncmp = 0;
  int nfail = 0;

  // Model: addresses accepted but not yet taken by memory, count of fetches
  // granted but not returned to the core, count memory still owes, and the
  // response seen one cycle ago (for the registered mode).
  logic [31:0] iss_q[$];
  int          out_n;
  int          mem_n;
  logic        r_v, r_e;
  logic [31:0] r_d;

  always #5 clk = ~clk;

  riscv_instr_req_slice #(.RDATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .RESP_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(req[0]), .core_gnt_o(gnt[0]), .core_addr_i(addr[0]),
    .core_rdata_o(crd[0]), .core_rvalid_o(crv[0]), .core_err_o(cer[0]),
    .instr_req_o(irq[0]), .instr_gnt_i(ign[0]), .instr_addr_o(iad[0]),
    .instr_rdata_i(ird[0]), .instr_rvalid_i(irv[0]), .instr_err_i(ier[0]),
    .busy_o(busy[0])
  );

  riscv_instr_req_slice #(.RDATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .RESP_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(req[1]), .core_gnt_o(gnt[1]), .core_addr_i(addr[1]),
    .core_rdata_o(crd[1]), .core_rvalid_o(crv[1]), .core_err_o(cer[1]),
    .instr_req_o(irq[1]), .instr_gnt_i(ign[1]), .instr_addr_o(iad[1]),
    .instr_rdata_i(ird[1]), .instr_rvalid_i(irv[1]), .instr_err_i(ier[1]),
    .busy_o(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = '0; ign[k] = 1'b0;
      irv[k] = 1'b0; ird[k] = '0; ier[k] = 1'b0;
    end
  endtask

  task automatic model_reset();
    iss_q.delete();
    out_n = 0; mem_n = 0;
    r_v = 1'b0; r_e = 1'b0; r_d = '0;
  endtask

  // One clock cycle on instance d: drive (just after posedge), check at
  // negedge against the model, advance the model, return just after posedge.
  task automatic cyc(input int d, input logic rq, input logic [31:0] ad, input logic g,
                     input logic rv, input logic [31:0] rd, input logic er);
    logic        e_gnt, e_rv, e_er, issued;
    logic [31:0] e_rd;
    if (mem_n == 0) rv = 1'b0;   // memory only answers what it was granted
    req[d] = rq; addr[d] = ad; ign[d] = g; irv[d] = rv; ird[d] = rd; ier[d] = er;
    @(negedge clk);
    e_gnt = rq && (iss_q.size() == 0) && (out_n < MAXO);
    if (d == 0) begin
      e_rv = rv; e_rd = rd; e_er = er & rv;
    end else begin
      e_rv = r_v; e_rd = r_d; e_er = r_e & r_v;
    end
    chk($sformatf("d%0d.core_gnt", d), 32'(gnt[d]), 32'(e_gnt));
    chk($sformatf("d%0d.instr_req", d), 32'(irq[d]), 32'(iss_q.size() != 0));
    if (iss_q.size() != 0) chk($sformatf("d%0d.instr_addr", d), iad[d], iss_q[0]);
    chk($sformatf("d%0d.core_rvalid", d), 32'(crv[d]), 32'(e_rv));
    chk($sformatf("d%0d.core_rdata", d), crd[d], e_rd);
    chk($sformatf("d%0d.core_err", d), 32'(cer[d]), 32'(e_er));
    chk($sformatf("d%0d.busy", d), 32'(busy[d]),
        32'((iss_q.size() != 0) || (out_n != 0) || rq));
    issued = (iss_q.size() != 0) && g;
    if (issued) begin
      void'(iss_q.pop_front());
      mem_n++;
    end
    if (e_gnt) iss_q.push_back(ad);
    if (rv) mem_n--;
    out_n = out_n + int'(e_gnt) - int'(e_rv);
    r_v = rv; r_e = er & rv;
    if (rv) r_d = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 30 && (out_n != 0 || iss_q.size() != 0); i++)
      cyc(d, 1'b0, 32'h0, 1'b1, mem_n > 0, $urandom, 1'b0);
    cyc(d, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rand_run(input int d, input int n);
    for (int i = 0; i < n; i++)
      cyc(d, ($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0,
          ($urandom % 2) != 0, $urandom, ($urandom % 5) == 0);
    drain(d);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d.core_gnt", k), 32'(gnt[k]), 32'h0);
      chk($sformatf("rst%0d.instr_req", k), 32'(irq[k]), 32'h0);
      chk($sformatf("rst%0d.instr_addr", k), iad[k], 32'h0);
      chk($sformatf("rst%0d.core_rvalid", k), 32'(crv[k]), 32'h0);
      chk($sformatf("rst%0d.core_rdata", k), crd[k], 32'h0);
      chk($sformatf("rst%0d.core_err", k), 32'(cer[k]), 32'h0);
      chk($sformatf("rst%0d.busy", k), 32'(busy[k]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, pass-through response
    cyc(0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Address change while blocked by the outstanding limit
    cyc(0, 1'b1, 32'h0000_00A0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_00A4, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 32'h1111_0000, 1'b0);
    cyc(0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drain(0);

    // Back-pressure: memory withholds grant for five cycles
    cyc(0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(0, 1'b1, 32'h0000_0304 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drain(0);

    // Outstanding limit: three requests, responses withheld
    cyc(0, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0404, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0404, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0408, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0408, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0408, 1'b1, 1'b1, 32'h2222_0000, 1'b0);
    cyc(0, 1'b1, 32'h0000_0408, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    drain(0);

    // Reset mid-transaction with slot full and two outstanding
    cyc(0, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0504, 1'b0, 1'b0, 32'h0, 1'b0);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("midrst.instr_req", 32'(irq[0]), 32'h0);
    chk("midrst.instr_addr", iad[0], 32'h0);
    chk("midrst.core_gnt", 32'(gnt[0]), 32'h0);
    chk("midrst.busy", 32'(busy[0]), 32'h0);
    chk("midrst.core_rvalid", 32'(crv[0]), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    cyc(0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    rand_run(0, 300);
    model_reset();

    // Registered response with error, then a clean response
    cyc(1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1, 1'b1, 32'h0000_2004, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1, 1'b1, 32'h0000_2004, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cyc(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h5555_5555, 1'b1);
    cyc(1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    cyc(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    rand_run(1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
